// File: rtl/run_detector.sv
// Serial run detector: flags RUN_LEN consecutive equal samples of w,
// with sticky or non-overlapping restart and a saturating detection count.
module run_detector #(
  parameter  int RUN_LEN = 4,
  parameter  int CNT_W   = 8,
  localparam int LW      = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             en,
  input  logic             w,
  input  logic             mode,
  input  logic             clr_cnt,
  output logic             z,
  output logic             z_val,
  output logic [1:0]       state,
  output logic [LW-1:0]    run_len,
  output logic [CNT_W-1:0] det_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN0 = 2'b01,
    RUN1 = 2'b10
  } state_t;

  localparam logic [LW-1:0]    FULL = LW'(RUN_LEN);
  localparam logic [LW-1:0]    ONE  = LW'(1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t           state_q, state_d;
  logic [LW-1:0]    len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_run;
  logic             same;
  logic             hit;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // The unused code 11 is not a run, so it restarts exactly like IDLE.
  always_comb begin
    in_run  = (state_q == RUN0) || (state_q == RUN1);
    same    = in_run && (w == (state_q == RUN1));
    state_d = state_q;
    len_d   = len_q;
    hit     = 1'b0;
    if (en) begin
      if (!same) begin
        state_d = w ? RUN1 : RUN0;
        len_d   = ONE;
      end else if (len_q < FULL) begin
        len_d = len_q + ONE;
        hit   = (len_q == FULL - ONE);
      end else if (mode) begin
        len_d = ONE;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != CMAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign z       = ((state_q == RUN0) || (state_q == RUN1)) && (len_q == FULL);
  assign z_val   = (state_q == RUN1);
  assign state   = state_q;
  assign run_len = len_q;
  assign det_cnt = cnt_q;

endmodule

// File: tb/tb_run_detector.sv
// Bench for run_detector: directed vector table, hand-written corner
// sequences and a random run against a per-instance arithmetic model.
module tb_run_detector;

  logic clk = 1'b0;
  logic aclr, en, w, mode, clr;

  logic       z2, zv2, z4, zv4, z5, zv5;
  logic [1:0] st2, st4, st5;
  logic [1:0] rl2;
  logic [2:0] rl4, rl5;
  logic [1:0] c2;
  logic [7:0] c4, c5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  run_detector #(.RUN_LEN(2), .CNT_W(2)) d2 (
    .clk(clk), .aclr(aclr), .en(en), .w(w), .mode(mode), .clr_cnt(clr),
    .z(z2), .z_val(zv2), .state(st2), .run_len(rl2), .det_cnt(c2)
  );
  run_detector #(.RUN_LEN(4), .CNT_W(8)) d4 (
    .clk(clk), .aclr(aclr), .en(en), .w(w), .mode(mode), .clr_cnt(clr),
    .z(z4), .z_val(zv4), .state(st4), .run_len(rl4), .det_cnt(c4)
  );
  run_detector #(.RUN_LEN(5), .CNT_W(8)) d5 (
    .clk(clk), .aclr(aclr), .en(en), .w(w), .mode(mode), .clr_cnt(clr),
    .z(z5), .z_val(zv5), .state(st5), .run_len(rl5), .det_cnt(c5)
  );

  int az[3], azv[3], ast[3], arl[3], acnt[3];
  always_comb begin
    az[0] = int'(z2);  azv[0] = int'(zv2); ast[0] = int'(st2);
    arl[0] = int'(rl2); acnt[0] = int'(c2);
    az[1] = int'(z4);  azv[1] = int'(zv4); ast[1] = int'(st4);
    arl[1] = int'(rl4); acnt[1] = int'(c4);
    az[2] = int'(z5);  azv[2] = int'(zv5); ast[2] = int'(st5);
    arl[2] = int'(rl5); acnt[2] = int'(c5);
  end

  // Reference: last sample value (-1 before any sample), run length, count.
  int NN[3] = '{2, 4, 5};
  int MC[3] = '{3, 255, 255};
  int mv[3], mrl[3], mcnt[3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = -1; mrl[k] = 0; mcnt[k] = 0;
    end
  endtask

  task automatic model_step();
    bit inc;
    for (int k = 0; k < 3; k++) begin
      inc = 0;
      if (en) begin
        if (mv[k] < 0 || int'(w) != mv[k]) begin
          mv[k] = int'(w); mrl[k] = 1;
        end else if (mrl[k] < NN[k]) begin
          mrl[k]++;
          inc = (mrl[k] == NN[k]);
        end else if (mode) begin
          mrl[k] = 1;
        end
      end
      if (clr) mcnt[k] = 0;
      else if (inc && mcnt[k] < MC[k]) mcnt[k]++;
    end
  endtask

  task automatic edge_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 0; w = 0; mode = 0; clr = 0;
    aclr = 1;
    edge_tick();
    aclr = 0;
    model_reset();
  endtask

  typedef struct {
    bit rst, en, w, mode, clr;
    bit ez, ezv;
    int est, erl, ecnt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit rst, input bit e, input bit ww, input bit m,
                     input bit c, input bit ez, input bit ezv,
                     input int est, input int erl, input int ecnt);
    vec_t v;
    v.rst = rst; v.en = e; v.w = ww; v.mode = m; v.clr = c;
    v.ez = ez; v.ezv = ezv; v.est = est; v.erl = erl; v.ecnt = ecnt;
    tbl.push_back(v);
  endtask

  initial begin
    aclr = 1; en = 0; w = 0; mode = 0; clr = 0;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("rst_z", az[k], 0);
      chk("rst_st", ast[k], 0);
      chk("rst_rl", arl[k], 0);
      chk("rst_cnt", acnt[k], 0);
    end
    do_reset();

    // RUN_LEN=4: sticky run of zeros, then non-overlapping ones, clr, mode.
    add(1,1,0,0,0, 0,0,1,1,0);
    add(0,1,0,0,0, 0,0,1,2,0);
    add(0,1,0,0,0, 0,0,1,3,0);
    add(0,1,0,0,0, 1,0,1,4,1);
    add(0,1,0,0,0, 1,0,1,4,1);
    add(0,1,1,0,0, 0,0,2,1,1);
    add(1,1,1,1,0, 0,0,2,1,0);
    add(0,1,1,1,0, 0,0,2,2,0);
    add(0,1,1,1,0, 0,0,2,3,0);
    add(0,1,1,1,0, 1,1,2,4,1);
    add(0,1,1,1,0, 0,0,2,1,1);
    add(0,1,1,1,0, 0,0,2,2,1);
    add(0,1,1,1,0, 0,0,2,3,1);
    add(0,1,1,1,0, 1,1,2,4,2);
    add(0,1,1,1,0, 0,0,2,1,2);
    add(0,1,1,1,0, 0,0,2,2,2);
    add(0,1,1,1,0, 0,0,2,3,2);
    add(0,1,1,1,1, 1,1,2,4,0);
    add(0,0,0,1,0, 1,1,2,4,0);
    add(0,1,1,0,0, 1,1,2,4,0);
    add(0,1,1,1,0, 0,0,2,1,0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      en = tbl[i].en; w = tbl[i].w; mode = tbl[i].mode; clr = tbl[i].clr;
      edge_tick();
      chk($sformatf("tbl%0d_z", i), az[1], int'(tbl[i].ez));
      if (tbl[i].ez) chk($sformatf("tbl%0d_zval", i), azv[1], int'(tbl[i].ezv));
      chk($sformatf("tbl%0d_st", i), ast[1], tbl[i].est);
      chk($sformatf("tbl%0d_rl", i), arl[1], tbl[i].erl);
      chk($sformatf("tbl%0d_cnt", i), acnt[1], tbl[i].ecnt);
    end
    clr = 0;

    // RUN_LEN=2: en gating holds run_len.
    do_reset();
    w = 1;
    en = 1; edge_tick(); chk("en_rl_e1", arl[0], 1);
    en = 0; edge_tick(); chk("en_rl_e2", arl[0], 1);
    chk("en_z_e2", az[0], 0);
    en = 1; edge_tick(); chk("en_z_e3", az[0], 1);
    chk("en_rl_e3", arl[0], 2);
    en = 0; edge_tick(); chk("en_rl_e4", arl[0], 2);
    chk("en_cnt", acnt[0], 1);

    // RUN_LEN=2, CNT_W=2: counter saturation, then clear on a hit edge.
    do_reset();
    en = 1; w = 0; mode = 1;
    for (int i = 0; i < 12; i++) edge_tick();
    chk("sat_cnt", acnt[0], 3);
    chk("sat_rl", arl[0], 2);
    edge_tick();
    chk("sat_rl13", arl[0], 1);
    clr = 1; edge_tick(); clr = 0;
    chk("clr_cnt", acnt[0], 0);
    chk("clr_z", az[0], 1);
    chk("clr_rl", arl[0], 2);

    // RUN_LEN=4: async clear mid-run between edges.
    do_reset();
    en = 1; mode = 0; w = 0;
    for (int i = 0; i < 4; i++) edge_tick();
    w = 1;
    for (int i = 0; i < 3; i++) edge_tick();
    chk("pre_rl", arl[1], 3);
    chk("pre_cnt", acnt[1], 1);
    #2 aclr = 1;
    #1;
    chk("aclr_st", ast[1], 0);
    chk("aclr_rl", arl[1], 0);
    chk("aclr_cnt", acnt[1], 0);
    chk("aclr_z", az[1], 0);
    chk("aclr_zv", azv[1], 0);
    aclr = 0;
    w = 1; en = 1;
    edge_tick();
    chk("post_st", ast[1], 2);
    chk("post_rl", arl[1], 1);

    // Random stimulus on all three instances against the model.
    do_reset();
    w = 0;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 3) == 0) w = ~w;
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      clr = ($urandom_range(0, 39) == 0);
      model_step();
      edge_tick();
      for (int k = 0; k < 3; k++) begin
        int ez, est;
        ez = (mv[k] >= 0 && mrl[k] == NN[k]) ? 1 : 0;
        est = (mv[k] < 0) ? 0 : (mv[k] == 1 ? 2 : 1);
        chk($sformatf("rnd%0d_k%0d_z", i, k), az[k], ez);
        chk($sformatf("rnd%0d_k%0d_st", i, k), ast[k], est);
        chk($sformatf("rnd%0d_k%0d_rl", i, k), arl[k], mrl[k]);
        chk($sformatf("rnd%0d_k%0d_cnt", i, k), acnt[k], mcnt[k]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
